se_req_arbiter: RTL and testbench

- Shares one SE compute instance between two independent requesters.
- Round-robin arbitration on the SE input handshake.
- In-order tag FIFO steers each SE result back to the requester that issued it.
- Records per-transaction issue-to-result latency; a sticky maximum feeds timing-leak characterisation runs.

---
 rtl/se_arb_pkg.sv | 16 +
 rtl/se_tag_fifo.sv | 61 ++++++
 rtl/se_req_arbiter.sv | 130 +++++++++++++
 tb/tb_se_req_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/se_arb_pkg.sv
// Shared types and default widths for the SE request arbiter and its tag FIFO.
package se_arb_pkg;

   localparam int DEF_INST_W = 8;
   localparam int DEF_DATA_W = 128;
   localparam int DEF_TS_W   = 16;

   typedef logic req_id_t;

   // Stamp is sized for the widest supported timestamp; narrower TS_W uses the low bits.
   typedef struct packed {
      req_id_t               id;
      logic [DEF_TS_W-1:0]   stamp;
   } tag_t;

endpackage

// File: rtl/se_tag_fifo.sv
// Synchronous DEPTH-entry FIFO holding in-flight SE transaction tags.
module se_tag_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      full_o  = (cnt_q == CNT_W'(DEPTH));
      empty_o = (cnt_q == '0);
      // A full FIFO refuses a push even when a pop frees a slot this cycle.
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
      rd_d    = do_pop ? rd_q + PTR_W'(1) : rd_q;
      cnt_d   = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/se_req_arbiter.sv
// Round-robin front end sharing one SE instance between two requesters.
// An in-order tag FIFO steers results home and timestamps each transaction.
module se_req_arbiter
   import se_arb_pkg::*;
#(
   parameter int INST_W = DEF_INST_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 4,
   parameter int TS_W   = DEF_TS_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [INST_W-1:0]        rq0_inst,
   input  logic [DATA_W-1:0]        rq0_op1,
   input  logic [DATA_W-1:0]        rq0_op2,
   input  logic [DATA_W-1:0]        rq0_cond,
   input  logic                     rq0_valid,
   output logic                     rq0_ready,
   input  logic [INST_W-1:0]        rq1_inst,
   input  logic [DATA_W-1:0]        rq1_op1,
   input  logic [DATA_W-1:0]        rq1_op2,
   input  logic [DATA_W-1:0]        rq1_cond,
   input  logic                     rq1_valid,
   output logic                     rq1_ready,
   output logic [DATA_W-1:0]        rs0_result,
   output logic                     rs0_valid,
   input  logic                     rs0_ready,
   output logic [DATA_W-1:0]        rs1_result,
   output logic                     rs1_valid,
   input  logic                     rs1_ready,
   output logic [INST_W-1:0]        se_inst,
   output logic [DATA_W-1:0]        se_op1,
   output logic [DATA_W-1:0]        se_op2,
   output logic [DATA_W-1:0]        se_cond,
   output logic                     se_valid,
   input  logic                     se_ready,
   input  logic [DATA_W-1:0]        se_result,
   input  logic                     se_out_valid,
   output logic                     se_out_ready,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic [TS_W-1:0]          last_latency,
   output logic [TS_W-1:0]          max_latency,
   output logic                     err_spurious
);

   logic [TS_W-1:0] ts_q, ts_d;
   logic [TS_W-1:0] last_q, last_d;
   logic [TS_W-1:0] max_q, max_d;
   logic [TS_W-1:0] lat;
   req_id_t         ptr_q, ptr_d;
   req_id_t         gnt;
   logic            err_q, err_d;
   logic            full, empty, issue, pop, head_rdy;
   tag_t            push_tag, head_tag;

   always_comb begin
      gnt       = (rq0_valid && rq1_valid) ? ptr_q : rq1_valid;
      se_valid  = !reset && (rq0_valid || rq1_valid) && !full;
      issue     = se_valid && se_ready;
      rq0_ready = issue && (gnt == 1'b0);
      rq1_ready = issue && (gnt == 1'b1);
      se_inst   = gnt ? rq1_inst : rq0_inst;
      se_op1    = gnt ? rq1_op1  : rq0_op1;
      se_op2    = gnt ? rq1_op2  : rq0_op2;
      se_cond   = gnt ? rq1_cond : rq0_cond;
      ptr_d     = (issue && (gnt == ptr_q)) ? ~ptr_q : ptr_q;
      push_tag.id    = gnt;
      push_tag.stamp = DEF_TS_W'(ts_q);
   end

   // With nothing outstanding the SE result is drained and flagged as spurious.
   always_comb begin
      head_rdy     = head_tag.id ? rs1_ready : rs0_ready;
      se_out_ready = !reset && (empty || head_rdy);
      rs0_valid    = !reset && se_out_valid && !empty && (head_tag.id == 1'b0);
      rs1_valid    = !reset && se_out_valid && !empty && (head_tag.id == 1'b1);
      rs0_result   = se_result;
      rs1_result   = se_result;
      pop          = se_out_valid && se_out_ready && !empty;
   end

   always_comb begin
      ts_d   = ts_q + TS_W'(1);
      lat    = ts_q - TS_W'(head_tag.stamp);
      last_d = last_q;
      max_d  = max_q;
      err_d  = err_q;
      if (pop) begin
         last_d = lat;
         if (lat > max_q) max_d = lat;
      end
      if (se_out_valid && empty) err_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ts_q   <= '0;
         ptr_q  <= 1'b0;
         last_q <= '0;
         max_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         ts_q   <= ts_d;
         ptr_q  <= ptr_d;
         last_q <= last_d;
         max_q  <= max_d;
         err_q  <= err_d;
      end
   end

   se_tag_fifo #(
      .WIDTH ($bits(tag_t)),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (issue),
      .din_i   (push_tag),
      .pop_i   (pop),
      .dout_o  (head_tag),
      .full_o  (full),
      .empty_o (empty),
      .count_o (outstanding)
   );

   assign last_latency = last_q;
   assign max_latency  = max_q;
   assign err_spurious = err_q;

endmodule

// File: tb/tb_se_req_arbiter.sv
// Scoreboard bench for se_req_arbiter: queued requesters, a delaying SE model, in-order result checks.
module tb_se_req_arbiter;

   localparam int IW    = 8;
   localparam int DW    = 128;
   localparam int DEPTH = 4;
   localparam int TW    = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct { logic [IW-1:0] inst; logic [DW-1:0] op1, op2, cond; } req_t;
   typedef struct { logic port; logic [DW-1:0] data; } exp_t;
   typedef struct { logic [DW-1:0] data; int due; } sepend_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic           reset;
   logic [IW-1:0]  rq0_inst, rq1_inst, se_inst;
   logic [DW-1:0]  rq0_op1, rq0_op2, rq0_cond, rq1_op1, rq1_op2, rq1_cond;
   logic           rq0_valid, rq0_ready, rq1_valid, rq1_ready;
   logic [DW-1:0]  rs0_result, rs1_result, se_op1, se_op2, se_cond, se_result;
   logic           rs0_valid, rs0_ready, rs1_valid, rs1_ready;
   logic           se_valid, se_ready, se_out_valid, se_out_ready, err_spurious;
   logic [CW-1:0]  outstanding;
   logic [TW-1:0]  last_latency, max_latency;

   logic           w_reset, w_rq0_valid, w_rq0_ready, w_rq1_ready;
   logic           w_rs0_valid, w_rs1_valid, w_se_valid, w_se_out_valid, w_se_out_ready, w_err;
   logic [IW-1:0]  w_se_inst;
   logic [DW-1:0]  w_rs0_result, w_rs1_result, w_se_op1, w_se_op2, w_se_cond;
   logic [CW-1:0]  w_outstanding;
   logic [3:0]     w_last, w_max;

   se_req_arbiter u_dut (
      .clock(clock), .reset(reset),
      .rq0_inst(rq0_inst), .rq0_op1(rq0_op1), .rq0_op2(rq0_op2), .rq0_cond(rq0_cond),
      .rq0_valid(rq0_valid), .rq0_ready(rq0_ready),
      .rq1_inst(rq1_inst), .rq1_op1(rq1_op1), .rq1_op2(rq1_op2), .rq1_cond(rq1_cond),
      .rq1_valid(rq1_valid), .rq1_ready(rq1_ready),
      .rs0_result(rs0_result), .rs0_valid(rs0_valid), .rs0_ready(rs0_ready),
      .rs1_result(rs1_result), .rs1_valid(rs1_valid), .rs1_ready(rs1_ready),
      .se_inst(se_inst), .se_op1(se_op1), .se_op2(se_op2), .se_cond(se_cond),
      .se_valid(se_valid), .se_ready(se_ready), .se_result(se_result),
      .se_out_valid(se_out_valid), .se_out_ready(se_out_ready),
      .outstanding(outstanding), .last_latency(last_latency), .max_latency(max_latency),
      .err_spurious(err_spurious)
   );

   // Narrow-timestamp instance used only for the wrap-around latency case.
   se_req_arbiter #(.TS_W(4)) u_dut_w (
      .clock(clock), .reset(w_reset),
      .rq0_inst(8'h11), .rq0_op1('0), .rq0_op2('0), .rq0_cond('0),
      .rq0_valid(w_rq0_valid), .rq0_ready(w_rq0_ready),
      .rq1_inst(8'h00), .rq1_op1('0), .rq1_op2('0), .rq1_cond('0),
      .rq1_valid(1'b0), .rq1_ready(w_rq1_ready),
      .rs0_result(w_rs0_result), .rs0_valid(w_rs0_valid), .rs0_ready(1'b1),
      .rs1_result(w_rs1_result), .rs1_valid(w_rs1_valid), .rs1_ready(1'b1),
      .se_inst(w_se_inst), .se_op1(w_se_op1), .se_op2(w_se_op2), .se_cond(w_se_cond),
      .se_valid(w_se_valid), .se_ready(1'b1), .se_result('0),
      .se_out_valid(w_se_out_valid), .se_out_ready(w_se_out_ready),
      .outstanding(w_outstanding), .last_latency(w_last), .max_latency(w_max),
      .err_spurious(w_err)
   );

   req_t    rq0_q[$], rq1_q[$];
   exp_t    exp_q[$];
   sepend_t se_pend[$];
   logic    grant_log[$];
   int      cyc, se_delay, se_release, rs1_cnt;
   bit      se_hold, se_rdy, rs0_rdy, rs1_rdy;
   int      n_checks, n_pass;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] se_fn(input logic [IW-1:0] inst,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
      return (a ^ b) + c + DW'(inst);
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.inst = IW'($urandom);
      r.op1  = {$urandom, $urandom, $urandom, $urandom};
      r.op2  = {$urandom, $urandom, $urandom, $urandom};
      r.cond = {$urandom, $urandom, $urandom, $urandom};
      return r;
   endfunction

   task automatic queue_req(input logic port, input req_t r);
      if (port) rq1_q.push_back(r);
      else      rq0_q.push_back(r);
   endtask

   task automatic expect_resp(input logic port, input req_t r);
      exp_t e;
      e.port = port;
      e.data = se_fn(r.inst, r.op1, r.op2, r.cond);
      exp_q.push_back(e);
   endtask

   task automatic send(input logic port, input req_t r);
      queue_req(port, r);
      expect_resp(port, r);
   endtask

   task automatic check_resp(input logic port, input logic [DW-1:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_eq("rs_extra", 32'(exp_q.size()), 1);
      end else begin
         e = exp_q.pop_front();
         check_eq("rs_port", port, e.port);
         check_eq("rs_data", data, e.data);
      end
   endtask

   task automatic do_reset(input bit keep_se);
      @(negedge clock);
      reset = 1'b1;
      rq0_q.delete(); rq1_q.delete(); exp_q.delete(); grant_log.delete();
      if (!keep_se) se_pend.delete();
      se_release = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic drain(input string tag, input int limit);
      int k = 0;
      while ((exp_q.size() != 0 || se_pend.size() != 0) && k < limit) begin
         @(negedge clock);
         k++;
      end
      check_eq(tag, 32'(exp_q.size() + se_pend.size()), 0);
   endtask

   task automatic mid();
      @(negedge clock);
      #3;
   endtask

   // Driver: requesters and SE output change 1 time unit after the falling edge.
   always begin
      @(negedge clock);
      #1;
      rq0_valid = (rq0_q.size() != 0);
      if (rq0_valid) {rq0_inst, rq0_op1, rq0_op2, rq0_cond} = {rq0_q[0].inst, rq0_q[0].op1, rq0_q[0].op2, rq0_q[0].cond};
      rq1_valid = (rq1_q.size() != 0);
      if (rq1_valid) {rq1_inst, rq1_op1, rq1_op2, rq1_cond} = {rq1_q[0].inst, rq1_q[0].op1, rq1_q[0].op2, rq1_q[0].cond};
      se_ready  = se_rdy;
      rs0_ready = rs0_rdy;
      rs1_ready = rs1_rdy;
      if (se_pend.size() != 0 && se_pend[0].due <= cyc && (!se_hold || se_release > 0)) begin
         se_out_valid = 1'b1;
         se_result    = se_pend[0].data;
      end else begin
         se_out_valid = 1'b0;
         se_result    = '0;
      end
   end

   // Monitor: handshakes are sampled just before the rising edge that commits them.
   always begin
      sepend_t p;
      @(negedge clock);
      #4;
      if (se_valid && se_ready) begin
         p.data = se_fn(se_inst, se_op1, se_op2, se_cond);
         p.due  = cyc + se_delay;
         se_pend.push_back(p);
         grant_log.push_back(rq1_ready);
         check_eq("issue_onehot", rq0_ready ^ rq1_ready, 1);
      end
      if (rq0_valid && rq0_ready && rq0_q.size() != 0) void'(rq0_q.pop_front());
      if (rq1_valid && rq1_ready && rq1_q.size() != 0) void'(rq1_q.pop_front());
      if (se_out_valid && se_out_ready && se_pend.size() != 0) begin
         void'(se_pend.pop_front());
         if (se_hold && se_release > 0) se_release--;
      end
      if (rs0_valid || rs1_valid) check_eq("rs_onehot", rs0_valid & rs1_valid, 0);
      if (rs0_valid && rs0_ready) check_resp(1'b0, rs0_result);
      if (rs1_valid && rs1_ready) check_resp(1'b1, rs1_result);
      if (rs1_valid) rs1_cnt++;
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      req_t r [6];
      logic b_order [4];
      sepend_t fake;
      b_order = '{1'b0, 1'b1, 1'b0, 1'b1};
      n_checks = 0; n_pass = 0; cyc = 0; rs1_cnt = 0;
      se_delay = 2; se_hold = 1'b0; se_release = 0;
      se_rdy = 1'b1; rs0_rdy = 1'b1; rs1_rdy = 1'b1;
      reset = 1'b1; w_reset = 1'b1; w_rq0_valid = 1'b0; w_se_out_valid = 1'b0;
      rq0_valid = 1'b0; rq1_valid = 1'b0; se_out_valid = 1'b0;

      // Activity during reset must be masked.
      rq0_q.push_back(rand_req());
      fake.data = '1; fake.due = 0;
      se_pend.push_back(fake);
      repeat (3) @(negedge clock);
      #3;
      check_eq("rst_se_valid", se_valid, 0);
      check_eq("rst_rq0_ready", rq0_ready, 0);
      check_eq("rst_se_out_ready", se_out_ready, 0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_last", last_latency, 0);
      check_eq("rst_max", max_latency, 0);
      check_eq("rst_err", err_spurious, 0);
      do_reset(1'b0);

      // Timestamp wrap with TS_W=4: issue at ts=14, result at ts=3 -> (3-14) mod 16 = 5.
      @(negedge clock);
      w_reset = 1'b0;
      repeat (14) @(negedge clock);
      w_rq0_valid = 1'b1;
      #3 check_eq("w_issue_ready", w_rq0_ready, 1);
      @(negedge clock);
      w_rq0_valid = 1'b0;
      repeat (4) @(negedge clock);
      w_se_out_valid = 1'b1;
      #3 check_eq("w_rs0_valid", w_rs0_valid, 1);
      @(negedge clock);
      w_se_out_valid = 1'b0;
      #3;
      check_eq("w_last_latency", w_last, 5);
      check_eq("w_max_latency", w_max, 5);

      // Single requester, SE answers two cycles after issue.
      do_reset(1'b0);
      rs1_cnt = 0; se_delay = 2;
      for (int i = 0; i < 3; i++) send(1'b0, rand_req());
      drain("a_drain", 40);
      check_eq("a_rs1_never", rs1_cnt, 0);
      check_eq("a_last_latency", last_latency, 2);
      check_eq("a_max_latency", max_latency, 2);
      check_eq("a_err", err_spurious, 0);

      // Contention: both requesters always valid -> alternating grants.
      do_reset(1'b0);
      se_delay = 1;
      for (int i = 0; i < 4; i++) r[i] = rand_req();
      queue_req(1'b0, r[0]); queue_req(1'b1, r[1]); queue_req(1'b0, r[2]); queue_req(1'b1, r[3]);
      for (int i = 0; i < 4; i++) expect_resp(b_order[i], r[i]);
      drain("b_drain", 40);
      check_eq("b_grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) check_eq("b_grant_order", grant_log[i], b_order[i]);

      // Full FIFO with held results, then release two results.
      do_reset(1'b0);
      se_delay = 1; se_hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         r[i] = rand_req();
         send(1'b0, r[i]);
      end
      repeat (7) @(negedge clock);
      #3;
      check_eq("c_full_outstanding", outstanding, 4);
      check_eq("c_full_rq0_valid", rq0_valid, 1);
      check_eq("c_full_rq0_ready", rq0_ready, 0);
      check_eq("c_full_se_valid", se_valid, 0);
      check_eq("c_held_op1", se_op1, r[4].op1);
      se_release = 2;
      mid();
      check_eq("c_pop_when_full_ov", se_out_valid & se_out_ready, 1);
      check_eq("c_pop_when_full_occ", outstanding, 4);
      check_eq("c_pop_when_full_ready", rq0_ready, 0);
      mid();
      check_eq("c_pushpop_occ", outstanding, 3);
      check_eq("c_pushpop_ready", rq0_ready, 1);
      check_eq("c_pushpop_ov", se_out_valid, 1);
      mid();
      check_eq("c_after_pushpop_occ", outstanding, 3);
      check_eq("c_push_only_ov", se_out_valid, 0);
      check_eq("c_push_only_ready", rq0_ready, 1);
      mid();
      check_eq("c_refull_occ", outstanding, 4);
      se_hold = 1'b0;
      drain("c_drain", 60);

      // Head-of-line: head belongs to stalled requester 1.
      do_reset(1'b0);
      se_delay = 1; se_hold = 1'b1; rs1_rdy = 1'b0;
      send(1'b1, rand_req());
      repeat (3) @(negedge clock);
      send(1'b0, rand_req());
      repeat (3) @(negedge clock);
      se_hold = 1'b0;
      repeat (3) @(negedge clock);
      #3;
      check_eq("d_se_out_valid", se_out_valid, 1);
      check_eq("d_se_out_ready", se_out_ready, 0);
      check_eq("d_rs1_valid", rs1_valid, 1);
      check_eq("d_rs0_valid", rs0_valid, 0);
      check_eq("d_outstanding", outstanding, 2);
      rs1_rdy = 1'b1;
      drain("d_drain", 40);
      check_eq("d_max_nonzero", max_latency != 0, 1);

      // Spurious result with nothing outstanding.
      fake.data = 128'hDEAD; fake.due = cyc;
      se_pend.push_back(fake);
      #3;
      check_eq("e_spur_ov", se_out_valid, 1);
      check_eq("e_spur_ready", se_out_ready, 1);
      check_eq("e_spur_rs", rs0_valid | rs1_valid, 0);
      repeat (3) @(negedge clock);
      #3;
      check_eq("e_err_sticky", err_spurious, 1);

      // Reset with two outstanding, then their stale results arrive.
      se_hold = 1'b1;
      send(1'b0, rand_req());
      send(1'b0, rand_req());
      repeat (5) @(negedge clock);
      #3;
      check_eq("f_outstanding_pre", outstanding, 2);
      do_reset(1'b1);
      #3;
      check_eq("f_outstanding", outstanding, 0);
      check_eq("f_max", max_latency, 0);
      check_eq("f_last", last_latency, 0);
      check_eq("f_err", err_spurious, 0);
      se_hold = 1'b0;
      begin
         int k = 0;
         while (se_pend.size() != 0 && k < 20) begin
            @(negedge clock);
            k++;
         end
      end
      #3;
      check_eq("f_stale_drained", se_pend.size(), 0);
      check_eq("f_stale_err", err_spurious, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
